fan_duty_sequencer: RTL and testbench
=====================================

Name: fan_duty_sequencer

Overview:
- Sequences the duty-cycle inputs of the PWM controller for fan drive: kick-start, rate-limited ramp, hold, ramp-down to stop.
- Sits between the 4-bit fan-speed setting and PWM_controller; drives its counterValue_i / minCounterValue_i.
- Tracks PWM period boundaries with its own period counter, which runs in lock-step with PWM_controller. Every output update therefore lands on a period boundary.

Parameters:
- COUNTER_BITWIDTH, 4: duty width; period width is COUNTER_BITWIDTH+1.
- KICK_PERIODS, 8: number of PWM periods at kick duty when starting from stop (≥1).
- KICK_VALUE, 2**COUNTER_BITWIDTH-1: duty value output during kick.
- RAMP_PERIODS, 2: PWM periods between ramp steps (≥1).
- STEP, 1: duty change per ramp step (≥1).

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset
- clk_en_i  in  1  tick enable; same signal that feeds PWM_controller
- target_i  in  COUNTER_BITWIDTH  requested duty; 0 = fan off
- minCounterValue_i  in  COUNTER_BITWIDTH  minimum-duty offset while running
- periodCounterValue_i  in  COUNTER_BITWIDTH+1  PWM period; same value fed to PWM_controller
- counterValue_o  out  COUNTER_BITWIDTH  to PWM_controller.counterValue_i
- minCounterValue_o  out  COUNTER_BITWIDTH  to PWM_controller.minCounterValue_i
- state_o  out  2  0=IDLE, 1=KICK, 2=RAMP, 3=HOLD
- busy_o  out  1  high in KICK or RAMP

Behaviour:
- One clock, clk_i. Reset rstn_i is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, all internal counters 0.

Period tracking:
- Registers pcnt and preg, both COUNTER_BITWIDTH+1 bits.
- On clk_en_i with pcnt==preg: pcnt←0, preg←periodCounterValue_i, and a boundary pulse bnd is asserted for that cycle.
- On clk_en_i otherwise: pcnt←pcnt+1.
- This mirrors PWM_controller exactly. The first clk_en_i after reset is a boundary.

General rules:
- All state and output changes occur only on bnd cycles. target_i and minCounterValue_i are sampled only on bnd.
- PWM_controller latches the new values at its next boundary. Effective latency is therefore exactly one PWM period after the bnd cycle.
- The internal duty register is the counterValue_o source.

State machine, evaluated on bnd only; t denotes the sampled target_i:
- IDLE:
  - counterValue_o = 0, minCounterValue_o = 0.
  - If t≠0: go to KICK, load kickcnt←KICK_PERIODS-1, set duty←KICK_VALUE, set minCounterValue_o←minCounterValue_i.
- KICK:
  - If t==0: abort to IDLE on this bnd with duty←0 and min←0.
  - Else if kickcnt==0: duty←t, go to HOLD.
  - Else: kickcnt←kickcnt-1.
  - The kick lasts KICK_PERIODS bnd events, counting the entry event.
- HOLD:
  - If t≠duty: go to RAMP, rampcnt←RAMP_PERIODS-1. No duty change on this bnd.
- RAMP:
  - If rampcnt≠0: rampcnt←rampcnt-1.
  - Else: step duty toward t by STEP, saturating exactly at t with no overshoot. Compute in COUNTER_BITWIDTH+1 bits, so there is no wrap at 0 or at 2**COUNTER_BITWIDTH-1. Reload rampcnt←RAMP_PERIODS-1.
  - If the new duty equals t and t≠0: go to HOLD.
  - If the new duty equals 0 and t==0: go to IDLE and clear min.
  - If t changes mid-ramp, the ramp retargets on the next step and can reverse direction.
- minCounterValue_o reloads from minCounterValue_i on every bnd while not IDLE.
- busy_o and state_o are registered with the state.
- Reset mid-operation returns everything to reset values immediately (asynchronous). The first clk_en_i after release is a bnd.
- clk_en_i low: everything frozen.

Decomposition:
- Shared package fan_pkg:
  - state encoding constants ST_IDLE, ST_KICK, ST_RAMP, ST_HOLD;
  - default COUNTER_BITWIDTH.
- One sub-module, pwm_period_tracker: the pcnt/preg mirror that generates bnd. It can be reused by later blocks (tachometer gating).
- The FSM and duty arithmetic stay in fan_duty_sequencer.

Test Plan:
- Run all scenarios with clk_en_i=1 and period=15 unless stated.
- Reset, then target 0 for 100 cycles -> outputs 0, state IDLE, busy 0; a bnd pulse every 16 cycles.
- Reset, target 9, min 3 -> first bnd enters KICK: counterValue_o=15, min=3, busy=1. After exactly 8 bnd, duty=9 and HOLD. Check the PWM_controller pin duty one period later.
- In HOLD at 9, set target 12 -> RAMP. duty goes 10, 11, 12, with steps every 2 bnd. HOLD at 12; busy drops on the same bnd.
- In HOLD at 2, set target 0 -> ramp 1, 0, then IDLE with min_o=0. No underflow; PWM pin stays low afterward.
- Target 0 during KICK at kick period 3 -> IDLE at the next bnd with outputs 0. Separately, assert rstn_i low mid-RAMP -> outputs 0 asynchronously, then restart with kick.
- Toggle clk_en_i at 1/3 rate and change period to 7 mid-run -> bnd stays aligned with PWM_controller counter wrap, and the new period takes effect one boundary later.

Source files
------------

// File: rtl/fan_pkg.sv
// fan_pkg: shared state encoding and default width for the fan duty blocks
package fan_pkg;
    localparam int COUNTER_BITWIDTH = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KICK = 2'd1,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
    } fan_state_t;
endpackage

// File: rtl/fan_duty_sequencer_if.sv
// fan_duty_sequencer_if: setting inputs and PWM-side outputs of the duty sequencer
interface fan_duty_sequencer_if import fan_pkg::*; #(
    parameter int COUNTER_BITWIDTH = fan_pkg::COUNTER_BITWIDTH
);
    logic [COUNTER_BITWIDTH-1:0] target_i;
    logic [COUNTER_BITWIDTH-1:0] minCounterValue_i;
    logic [COUNTER_BITWIDTH:0]   periodCounterValue_i;
    logic [COUNTER_BITWIDTH-1:0] counterValue_o;
    logic [COUNTER_BITWIDTH-1:0] minCounterValue_o;
    logic [1:0]                  state_o;
    logic                        busy_o;
    modport master (
        output target_i, minCounterValue_i, periodCounterValue_i,
        input  counterValue_o, minCounterValue_o, state_o, busy_o
    );
    modport slave (
        input  target_i, minCounterValue_i, periodCounterValue_i,
        output counterValue_o, minCounterValue_o, state_o, busy_o
    );
endinterface

// File: rtl/pwm_period_tracker.sv
// pwm_period_tracker: mirrors the PWM_controller period counter and flags each boundary
module pwm_period_tracker #(
    parameter int COUNTER_BITWIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      clk_en_i,
    input  logic [COUNTER_BITWIDTH:0] period_i,
    output logic                      bnd_o
);
    logic [COUNTER_BITWIDTH:0] pcnt;
    logic [COUNTER_BITWIDTH:0] preg;

    assign bnd_o = clk_en_i && (pcnt == preg);

    // Wrap and reload the period on a boundary, otherwise count enabled ticks
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pcnt <= '0;
            preg <= '0;
        end else if (bnd_o) begin
            pcnt <= '0;
            preg <= period_i;
        end else if (clk_en_i) begin
            pcnt <= pcnt + 1'b1;
        end
    end
endmodule

// File: rtl/fan_duty_sequencer.sv
// fan_duty_sequencer: kick-start, rate-limited ramp and hold of the fan PWM duty
module fan_duty_sequencer import fan_pkg::*; #(
    parameter int COUNTER_BITWIDTH = fan_pkg::COUNTER_BITWIDTH,
    parameter int KICK_PERIODS     = 8,
    parameter int KICK_VALUE       = 2**COUNTER_BITWIDTH - 1,
    parameter int RAMP_PERIODS     = 2,
    parameter int STEP             = 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clk_en_i,
    fan_duty_sequencer_if.slave   bus
);
    localparam int W  = COUNTER_BITWIDTH;
    localparam int KW = $clog2(KICK_PERIODS + 1);
    localparam int RW = $clog2(RAMP_PERIODS + 1);
    localparam logic [W:0]    STEP_WIDE = (W+1)'(STEP);
    localparam logic [W-1:0]  STEP_NARROW = W'(STEP);
    localparam logic [W-1:0]  KICK_DUTY = W'(KICK_VALUE);
    localparam logic [KW-1:0] KICK_LOAD = KW'(KICK_PERIODS - 1);
    localparam logic [RW-1:0] RAMP_LOAD = RW'(RAMP_PERIODS - 1);

    fan_state_t    state, state_n;
    logic [W-1:0]  duty, duty_n;
    logic [W-1:0]  minv, minv_n;
    logic [KW-1:0] kickcnt, kickcnt_n;
    logic [RW-1:0] rampcnt, rampcnt_n;
    logic          bnd;
    logic          up;
    logic          near;
    logic [W:0]    diff;
    logic [W-1:0]  stepped;
    logic [W-1:0]  t;

    pwm_period_tracker #(.COUNTER_BITWIDTH(W)) u_tracker (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clk_en_i (clk_en_i),
        .period_i (bus.periodCounterValue_i),
        .bnd_o    (bnd)
    );

    assign t = bus.target_i;

    // One ramp step toward the target; the distance is taken one bit wider so
    // neither direction can wrap, and a step that would pass the target lands on it
    always_comb begin
        up      = duty < t;
        diff    = up ? ({1'b0, t} - {1'b0, duty}) : ({1'b0, duty} - {1'b0, t});
        near    = diff <= STEP_WIDE;
        stepped = near ? t : (up ? duty + STEP_NARROW : duty - STEP_NARROW);
    end

    // Next-state and duty decisions, acted on only at PWM period boundaries
    always_comb begin
        state_n   = state;
        duty_n    = duty;
        minv_n    = minv;
        kickcnt_n = kickcnt;
        rampcnt_n = rampcnt;
        if (bnd) begin
            minv_n = bus.minCounterValue_i;
            case (state)
                ST_IDLE: begin
                    minv_n = '0;
                    if (t != '0) begin
                        state_n   = ST_KICK;
                        kickcnt_n = KICK_LOAD;
                        duty_n    = KICK_DUTY;
                        minv_n    = bus.minCounterValue_i;
                    end
                end
                ST_KICK: begin
                    if (t == '0) begin
                        state_n = ST_IDLE;
                        duty_n  = '0;
                        minv_n  = '0;
                    end else if (kickcnt == '0) begin
                        state_n = ST_HOLD;
                        duty_n  = t;
                    end else begin
                        kickcnt_n = kickcnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (t != duty) begin
                        state_n   = ST_RAMP;
                        rampcnt_n = RAMP_LOAD;
                    end
                end
                ST_RAMP: begin
                    if (rampcnt != '0) begin
                        rampcnt_n = rampcnt - 1'b1;
                    end else begin
                        duty_n    = stepped;
                        rampcnt_n = RAMP_LOAD;
                        if (stepped == t && t != '0) begin
                            state_n = ST_HOLD;
                        end else if (stepped == '0 && t == '0) begin
                            state_n = ST_IDLE;
                            minv_n  = '0;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= ST_IDLE;
            duty    <= '0;
            minv    <= '0;
            kickcnt <= '0;
            rampcnt <= '0;
        end else begin
            state   <= state_n;
            duty    <= duty_n;
            minv    <= minv_n;
            kickcnt <= kickcnt_n;
            rampcnt <= rampcnt_n;
        end
    end

    assign bus.counterValue_o    = duty;
    assign bus.minCounterValue_o = minv;
    assign bus.state_o           = state;
    assign bus.busy_o            = (state == ST_KICK) || (state == ST_RAMP);
endmodule

// File: tb/tb_fan_duty_sequencer.sv
// tb_fan_duty_sequencer: directed checks of kick, ramp, hold, stop, abort, reset and period change
module tb_fan_duty_sequencer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clk_en = 1'b1;
    logic slow = 1'b0;
    int   ecnt = 0;
    int   total = 0;
    int   bad = 0;

    logic [4:0] m_pc, m_pr;
    logic [3:0] pwm_duty;
    logic       m_bnd;

    fan_duty_sequencer_if #(.COUNTER_BITWIDTH(4)) bus ();

    fan_duty_sequencer #(.COUNTER_BITWIDTH(4)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .clk_en_i (clk_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Enable pattern: continuous, or one tick in three
    always @(posedge clk) begin
        #1;
        ecnt++;
        clk_en = slow ? (ecnt % 3 == 0) : 1'b1;
    end

    // Reference PWM_controller: period counter and the duty it latches at each wrap
    assign m_bnd = clk_en && (m_pc == m_pr);
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pc     <= '0;
            m_pr     <= '0;
            pwm_duty <= '0;
        end else if (m_bnd) begin
            m_pc     <= '0;
            m_pr     <= bus.periodCounterValue_i;
            pwm_duty <= bus.counterValue_o;
        end else if (clk_en) begin
            m_pc <= m_pc + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Park on the negedge just before a boundary edge
    task automatic wait_bnd();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_bnd) return;
        end
        total++;
        bad++;
        $error("FAIL bnd_timeout observed=none expected=boundary");
    endtask

    task automatic fire();
        @(posedge clk);
        #1;
    endtask

    task automatic next_bnd();
        wait_bnd();
        fire();
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic [3:0] mn,
                           input logic [1:0] st, input logic b);
        chk({tag, "_duty"}, 32'(bus.counterValue_o), 32'(d));
        chk({tag, "_min"}, 32'(bus.minCounterValue_o), 32'(mn));
        chk({tag, "_state"}, 32'(bus.state_o), 32'(st));
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'(b));
    endtask

    logic [3:0] up_d [7]  = '{4'd9, 4'd9, 4'd10, 4'd10, 4'd11, 4'd11, 4'd12};
    logic [1:0] up_s [7]  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    logic [3:0] dn_d [5]  = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    logic [1:0] dn_s [5]  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};

    initial begin
        bus.target_i = '0;
        bus.minCounterValue_i = 4'd3;
        bus.periodCounterValue_i = 5'd15;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 4'd0, 4'd0, 2'd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        repeat (100) @(posedge clk);
        #1;
        chk_out("idle", 4'd0, 4'd0, 2'd0, 1'b0);

        bus.target_i = 4'd9;
        next_bnd();
        chk_out("kick_entry", 4'd15, 4'd3, 2'd1, 1'b1);
        repeat (7) next_bnd();
        chk_out("kick_last", 4'd15, 4'd3, 2'd1, 1'b1);
        next_bnd();
        chk_out("kick_done", 4'd9, 4'd3, 2'd3, 1'b0);
        chk("pwm_still_kick", 32'(pwm_duty), 32'd15);
        next_bnd();
        chk("pwm_latency", 32'(pwm_duty), 32'd9);

        bus.target_i = 4'd12;
        for (int i = 0; i < 7; i++) begin
            next_bnd();
            chk("ramp_up_duty", 32'(bus.counterValue_o), 32'(up_d[i]));
            chk("ramp_up_state", 32'(bus.state_o), 32'(up_s[i]));
        end
        chk("ramp_up_busy", 32'(bus.busy_o), 32'd0);

        bus.target_i = 4'd2;
        next_bnd();
        for (int i = 0; i < 40 && bus.state_o != 2'd3; i++) next_bnd();
        chk_out("hold_at_2", 4'd2, 4'd3, 2'd3, 1'b0);

        bus.target_i = 4'd0;
        for (int i = 0; i < 5; i++) begin
            next_bnd();
            chk("ramp_dn_duty", 32'(bus.counterValue_o), 32'(dn_d[i]));
            chk("ramp_dn_state", 32'(bus.state_o), 32'(dn_s[i]));
        end
        chk_out("stopped", 4'd0, 4'd0, 2'd0, 1'b0);
        repeat (2) next_bnd();
        chk("stop_pwm", 32'(pwm_duty), 32'd0);
        chk("stop_duty", 32'(bus.counterValue_o), 32'd0);

        bus.target_i = 4'd5;
        next_bnd();
        chk_out("abort_kick1", 4'd15, 4'd3, 2'd1, 1'b1);
        repeat (2) next_bnd();
        chk("abort_kick3", 32'(bus.state_o), 32'd1);
        bus.target_i = 4'd0;
        next_bnd();
        chk_out("abort", 4'd0, 4'd0, 2'd0, 1'b0);

        bus.target_i = 4'd9;
        repeat (9) next_bnd();
        chk("pre_rst_hold", 32'(bus.counterValue_o), 32'd9);
        bus.target_i = 4'd11;
        next_bnd();
        chk("pre_rst_ramp", 32'(bus.state_o), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk_out("async_rst", 4'd0, 4'd0, 2'd0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        next_bnd();
        chk_out("restart", 4'd15, 4'd3, 2'd1, 1'b1);

        slow = 1'b1;
        bus.periodCounterValue_i = 5'd7;
        for (int i = 0; i < 20 && bus.state_o != 2'd3; i++) next_bnd();
        chk_out("slow_hold", 4'd11, 4'd3, 2'd3, 1'b0);
        bus.target_i = 4'd13;
        wait_bnd();
        chk("slow_pre_a", 32'(bus.state_o), 32'd3);
        fire();
        chk("slow_post_a", 32'(bus.state_o), 32'd2);
        next_bnd();
        wait_bnd();
        chk("slow_pre_c", 32'(bus.counterValue_o), 32'd11);
        fire();
        chk("slow_post_c", 32'(bus.counterValue_o), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
